// File: rtl/uart_dbg_bridge.sv
// ============================================================================
// Module   : uart_dbg_bridge
// Purpose  : UART download bridge. Receives framed words, writes them to memory, and replies ACK/NAK.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_dbg_bridge #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int UART_BPS     = 19200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        busy_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_wr_addr_o,
    output logic [31:0] mem_wr_data_o
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int CNT_W        = $clog2(BAUD_CNT_MAX + 1);
    localparam int TO_CYC       = TIMEOUT_BITS * BAUD_CNT_MAX;
    localparam int TO_W         = $clog2(TO_CYC + 1);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_CNT_MAX / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);
    localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_ADDR = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_RESP = 3'd5
    } fr_state_t;

    // RX path registers
    logic             rx_meta_q,  rx_meta_d;
    logic             rx_sync_q,  rx_sync_d;
    logic             rx_prev_q,  rx_prev_d;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
    logic [2:0]       rx_bit_q,   rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_byte_q,  rx_byte_d;
    logic             rx_ferr_q,  rx_ferr_d;

    // Frame / TX registers
    fr_state_t        fr_state_q, fr_state_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      addr_q,     addr_d;
    logic [15:0]      len_q,      len_d;
    logic [31:0]      word_q,     word_d;
    logic [7:0]       xsum_q,     xsum_d;
    logic [TO_W-1:0]  timer_q,    timer_d;
    logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
    logic [3:0]       tx_idx_q,   tx_idx_d;
    logic [9:0]       tx_shift_q, tx_shift_d;
    logic             tx_q,       tx_d;
    logic             busy_q,     busy_d;
    logic             wr_en_q,    wr_en_d;
    logic [31:0]      wr_addr_q,  wr_addr_d;
    logic [31:0]      wr_data_q,  wr_data_d;

    logic start_edge;
    logic timed;
    logic timer_run;

    assign start_edge = rx_prev_q & ~rx_sync_q;

    always_comb begin
        rx_meta_d  = uart_rx_i;
        rx_sync_d  = rx_meta_q;
        rx_prev_d  = rx_sync_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_byte_d  = rx_byte_q;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (start_edge) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = rx_shift_q;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // The inter-byte timer only counts while the receiver is idle between bytes.
    assign timed     = (fr_state_q == ST_ADDR) || (fr_state_q == ST_LEN) ||
                       (fr_state_q == ST_DATA) || (fr_state_q == ST_CSUM);
    assign timer_run = timed && (rx_state_q == RX_IDLE) && !start_edge && !rx_valid_q;

    always_comb begin
        fr_state_d = fr_state_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        len_d      = len_q;
        word_d     = word_q;
        xsum_d     = xsum_q;
        timer_d    = timer_run ? (timer_q + TO_ONE) : '0;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        case (fr_state_q)
            ST_SYNC: begin
                if (rx_valid_q && (rx_byte_q == 8'hA5)) begin
                    fr_state_d = ST_ADDR;
                    busy_d     = 1'b1;
                    byte_idx_d = 2'd0;
                    xsum_d     = 8'h00;
                end
            end
            ST_ADDR: begin
                if (rx_valid_q) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        addr_d     = {rx_byte_q, addr_q[31:10], 2'b00};
                        fr_state_d = ST_LEN;
                    end else begin
                        addr_d = {rx_byte_q, addr_q[31:8]};
                    end
                end
            end
            ST_LEN: begin
                if (rx_valid_q) begin
                    len_d      = {rx_byte_q, len_q[15:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd1) begin
                        byte_idx_d = 2'd0;
                        fr_state_d = ({rx_byte_q, len_q[15:8]} == 16'd0) ? ST_CSUM : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid_q) begin
                    word_d     = {rx_byte_q, word_q[31:8]};
                    xsum_d     = xsum_q ^ rx_byte_q;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = {rx_byte_q, word_q[31:8]};
                        addr_d    = addr_q + 32'd4;
                        len_d     = len_q - 16'd1;
                        if (len_q == 16'd1) begin
                            fr_state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (rx_valid_q) begin
                    fr_state_d = ST_RESP;
                    tx_shift_d = {1'b1, (rx_byte_q == xsum_q) ? 8'h5A : 8'hEE, 1'b0};
                    tx_d       = 1'b0;
                    tx_cnt_d   = '0;
                    tx_idx_d   = 4'd0;
                end
            end
            ST_RESP: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 4'd9) begin
                        fr_state_d = ST_SYNC;
                        busy_d     = 1'b0;
                        tx_d       = 1'b1;
                    end else begin
                        tx_idx_d   = tx_idx_q + 4'd1;
                        tx_shift_d = {1'b1, tx_shift_q[9:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: fr_state_d = ST_SYNC;
        endcase
        // Framing error or inter-byte silence abandons the frame without a reply.
        if (timed && (rx_ferr_q || (timer_run && (timer_q == TO_LAST)))) begin
            fr_state_d = ST_SYNC;
            busy_d     = 1'b0;
            timer_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= 8'h00;
            rx_ferr_q  <= 1'b0;
            fr_state_q <= ST_SYNC;
            byte_idx_q <= 2'd0;
            addr_q     <= 32'd0;
            len_q      <= 16'd0;
            word_q     <= 32'd0;
            xsum_q     <= 8'h00;
            timer_q    <= '0;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 4'd0;
            tx_shift_q <= 10'h3FF;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= 32'd0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= rx_byte_d;
            rx_ferr_q  <= rx_ferr_d;
            fr_state_q <= fr_state_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            word_q     <= word_d;
            xsum_q     <= xsum_d;
            timer_q    <= timer_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign uart_tx_o     = tx_q;
    assign busy_o        = busy_q;
    assign mem_wr_en_o   = wr_en_q;
    assign mem_wr_addr_o = wr_addr_q;
    assign mem_wr_data_o = wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_dbg_bridge.sv
// ============================================================================
// Module   : tb_uart_dbg_bridge
// Purpose  : Directed self-checking bench for uart_dbg_bridge (10 clocks per bit).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_dbg_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx_i = 1'b1;
    logic        uart_tx_o;
    logic        busy_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_wr_addr_o;
    logic [31:0] mem_wr_data_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  tx_bytes[$];
    int          tx_low_cycles = 0;

    always #5 clk = ~clk;

    uart_dbg_bridge #(
        .CLK_FREQ    (1_000_000),
        .UART_BPS    (100_000),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx_i    (uart_rx_i),
        .uart_tx_o    (uart_tx_o),
        .busy_o       (busy_o),
        .mem_wr_en_o  (mem_wr_en_o),
        .mem_wr_addr_o(mem_wr_addr_o),
        .mem_wr_data_o(mem_wr_data_o)
    );

    always @(negedge clk) begin
        if (mem_wr_en_o === 1'b1) begin
            wr_addr.push_back(mem_wr_addr_o);
            wr_data.push_back(mem_wr_data_o);
        end
        if (uart_tx_o === 1'b0) tx_low_cycles++;
    end

    // Host-side receiver for the response byte: mid-bit sampling.
    always begin : tx_mon
        logic [7:0] b;
        @(negedge clk);
        if (rst === 1'b0 && uart_tx_o === 1'b0) begin
            repeat (5) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (10) @(negedge clk);
                b[i] = uart_tx_o;
            end
            repeat (10) @(negedge clk);
            if (uart_tx_o === 1'b1) tx_bytes.push_back(b);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (10) @(negedge clk);
        end
        uart_rx_i = ~bad_stop;
        repeat (10) @(negedge clk);
        uart_rx_i = 1'b1;
    endtask

    // First byte sits in the most significant occupied byte of 'bytes'.
    task automatic send_seq(input logic [127:0] bytes, input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[8*(n-1-i) +: 8], 1'b0);
    endtask

    task automatic wait_tx(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'h00;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (tx_bytes.size() > 0) begin
                b  = tx_bytes.pop_front();
                ok = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (busy_o === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        tx_bytes.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (uart_tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", uart_tx_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (mem_wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", mem_wr_en_o); end
        checks++; if (mem_wr_addr_o !== 32'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_wr_addr_o); end
        checks++; if (mem_wr_data_o !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", mem_wr_data_o); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [7:0] b;
        bit ok;
        clear_logs();
        send_byte(8'hA5, 1'b0);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy_after_sync got=%b exp=1", busy_o); end
        send_seq(128'h00100000_0100_78563412, 10);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy_mid_frame got=%b exp=1", busy_o); end
        send_byte(8'h08, 1'b0);
        wait_tx(b, ok);
        checks++; if (!ok || b !== 8'h5A) begin errors++; $display("FAIL t1_resp got=%h ok=%0d exp=5a", b, ok); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy_during_resp got=%b exp=1", busy_o); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL t1_busy_fall got=1 exp=0"); end
        checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL t1_wr_count got=%0d exp=1", wr_addr.size()); end
        else begin
            checks++; if (wr_addr[0] !== 32'h00001000) begin errors++; $display("FAIL t1_wr_addr got=%h exp=00001000", wr_addr[0]); end
            checks++; if (wr_data[0] !== 32'h12345678) begin errors++; $display("FAIL t1_wr_data got=%h exp=12345678", wr_data[0]); end
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] b;
        bit ok;
        clear_logs();
        send_seq(128'hA5_02000000_0200_DDCCBBAA_44332211_00, 16);
        wait_tx(b, ok);
        checks++; if (!ok || b !== 8'hEE) begin errors++; $display("FAIL t2_resp got=%h ok=%0d exp=ee", b, ok); end
        wait_idle(ok);
        checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL t2_wr_count got=%0d exp=2", wr_addr.size()); end
        else begin
            checks++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hAABBCCDD) begin errors++; $display("FAIL t2_wr0 got=%h:%h exp=00000000:aabbccdd", wr_addr[0], wr_data[0]); end
            checks++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h11223344) begin errors++; $display("FAIL t2_wr1 got=%h:%h exp=00000004:11223344", wr_addr[1], wr_data[1]); end
        end
    endtask

    task automatic test_zero_len_sync_filter();
        logic [7:0] b;
        bit ok;
        clear_logs();
        send_byte(8'h00, 1'b0);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t3_busy_garbage0 got=%b exp=0", busy_o); end
        send_byte(8'hFF, 1'b0);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t3_busy_garbage1 got=%b exp=0", busy_o); end
        send_seq(128'hA5_20000000_0000_00, 8);
        wait_tx(b, ok);
        checks++; if (!ok || b !== 8'h5A) begin errors++; $display("FAIL t3_resp got=%h ok=%0d exp=5a", b, ok); end
        wait_idle(ok);
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL t3_wr_count got=%0d exp=0", wr_addr.size()); end
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        bit ok;
        int cyc;
        int tx_before;
        clear_logs();
        tx_before = tx_low_cycles;
        send_seq(128'hA5_0000, 3);
        cyc = 0;
        while (busy_o === 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        // 200 cycles from the byte's receive strobe, which lands just before the wire-level stop-bit end.
        checks++; if (cyc < 197 || cyc > 202) begin errors++; $display("FAIL t4_timeout_cycles got=%0d exp=199 (197..202)", cyc); end
        repeat (60) @(negedge clk);
        checks++; if (tx_low_cycles != tx_before) begin errors++; $display("FAIL t4_no_tx got=%0d exp=%0d", tx_low_cycles, tx_before); end
        send_seq(128'hA5_00010000_0100_EFBEADDE_22, 12);
        wait_tx(b, ok);
        checks++; if (!ok || b !== 8'h5A) begin errors++; $display("FAIL t4_resp got=%h ok=%0d exp=5a", b, ok); end
        wait_idle(ok);
        checks++; if (wr_addr.size() != 1 || wr_addr[0] !== 32'h100 || wr_data[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL t4_wr got_count=%0d exp=1 at 00000100:deadbeef", wr_addr.size());
        end
    endtask

    task automatic test_framing_error();
        int tx_before;
        clear_logs();
        tx_before = tx_low_cycles;
        send_seq(128'hA5_00020000_0100_1122, 9);
        send_byte(8'h33, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t5_busy got=%b exp=0", busy_o); end
        send_byte(8'h44, 1'b0);
        repeat (300) @(negedge clk);
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL t5_wr_count got=%0d exp=0", wr_addr.size()); end
        checks++; if (tx_low_cycles != tx_before) begin errors++; $display("FAIL t5_no_tx got=%0d exp=%0d", tx_low_cycles, tx_before); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] b;
        bit ok;
        clear_logs();
        send_seq(128'hA5_00030000_0100_1122, 9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy_o !== 1'b0 || uart_tx_o !== 1'b1 || mem_wr_en_o !== 1'b0) begin
            errors++; $display("FAIL t6_rst_ctrl got busy=%b tx=%b wr=%b exp=0,1,0", busy_o, uart_tx_o, mem_wr_en_o);
        end
        checks++; if (mem_wr_addr_o !== 32'd0 || mem_wr_data_o !== 32'd0) begin
            errors++; $display("FAIL t6_rst_bus got=%h:%h exp=0:0", mem_wr_addr_o, mem_wr_data_o);
        end
        repeat (50) @(negedge clk);
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL t6_no_wr got=%0d exp=0", wr_addr.size()); end
        send_seq(128'hA5_00040000_0100_04030201_04, 12);
        wait_tx(b, ok);
        checks++; if (!ok || b !== 8'h5A) begin errors++; $display("FAIL t6_resp got=%h ok=%0d exp=5a", b, ok); end
        wait_idle(ok);
        checks++; if (wr_addr.size() != 1 || wr_addr[0] !== 32'h400 || wr_data[0] !== 32'h01020304) begin
            errors++; $display("FAIL t6_wr got_count=%0d exp=1 at 00000400:01020304", wr_addr.size());
        end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] b;
        bit ok;
        clear_logs();
        send_seq(128'hA5_FCFFFFFF_0200_A5000000_02000000_A7, 16);
        wait_tx(b, ok);
        checks++; if (!ok || b !== 8'h5A) begin errors++; $display("FAIL t7_resp got=%h ok=%0d exp=5a", b, ok); end
        wait_idle(ok);
        checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL t7_wr_count got=%0d exp=2", wr_addr.size()); end
        else begin
            checks++; if (wr_addr[0] !== 32'hFFFFFFFC || wr_data[0] !== 32'h000000A5) begin errors++; $display("FAIL t7_wr0 got=%h:%h exp=fffffffc:000000a5", wr_addr[0], wr_data[0]); end
            checks++; if (wr_addr[1] !== 32'h0 || wr_data[1] !== 32'h00000002) begin errors++; $display("FAIL t7_wr1 got=%h:%h exp=00000000:00000002", wr_addr[1], wr_data[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_bad_checksum();
        test_zero_len_sync_filter();
        test_timeout();
        test_framing_error();
        test_reset_mid_word();
        test_addr_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_dbg_bridge.md
# uart_dbg_bridge

UART download bridge that lets a host PC load program/data words into on-chip memory without CPU involvement. It receives a framed command stream on a UART RX pin, assembles little-endian 32-bit words, issues single-cycle memory write strobes at incrementing word addresses, and returns a one-byte ACK or NAK on a UART TX pin. It sits beside the CPU's UART peripheral at the top level. `busy_o` holds the core in stall while a download is in progress.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `UART_BPS`, default 19200: baud rate. Bit period `BAUD_CNT_MAX = CLK_FREQ/UART_BPS` cycles.
- `TIMEOUT_BITS`, default 20: inter-byte timeout, in bit periods.
- `clk`, input, 1: the single clock; every register is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `uart_rx_i`, input, 1: serial in from the host; idle high; asynchronous.
- `uart_tx_o`, output, 1: serial out to the host; idle high.
- `busy_o`, output, 1: download in progress; drives the CPU hold.
- `mem_wr_en_o`, output, 1: one-cycle memory write strobe.
- `mem_wr_addr_o`, output, 32: byte address of the write, always word-aligned.
- `mem_wr_data_o`, output, 32: write data.

## Operation
**Bit format.** 8N1, LSB first.

**RX path.**
- `uart_rx_i` passes through a 2-flop synchronizer before any use.
- In the RX idle state, a synchronized 1→0 edge starts a byte.
- The start bit is re-checked at mid-bit (count `BAUD_CNT_MAX/2-1`). If it reads 1, the byte is discarded and RX returns to idle.
- Each of the 8 data bits is sampled at its mid-bit.
- The stop bit is sampled at mid-bit. If it reads 0 this is a framing error: the byte is dropped and the frame FSM returns to `SYNC` with no response.
- A good byte produces a one-cycle `rx_valid` pulse with `rx_byte`.

**Frame FSM.** States: `SYNC`, `ADDR`, `LEN`, `DATA`, `CSUM`, `RESP`.
- **SYNC**: byte 0xA5 → `ADDR`, and `busy_o` rises. Any other byte is ignored.
- **ADDR**: takes 4 bytes, little-endian, into `addr`. `addr[1:0]` is forced to 0. Then → `LEN`.
- **LEN**: takes 2 bytes, little-endian, into a 16-bit word count `N`. If N=0 → `CSUM`, otherwise → `DATA`.
- **DATA**: bytes are shifted into a little-endian word.
  - Every 4th byte produces a write of `{addr, word}`; then `addr += 4` (32-bit wrap) and `N -= 1`.
  - When `N` reaches 0 → `CSUM`.
- **CSUM**: takes 1 byte. It is compared with `xsum`, the XOR of every DATA byte (`xsum` is reset to 0 on entering `ADDR`).
  - Match → send 0x5A.
  - Mismatch → send 0xEE.
  - Then → `RESP`.
- **RESP**: the TX serializer sends the byte as start, 8 data bits, stop. On completion of the stop bit → `SYNC`, and `busy_o` falls.

**Write ordering.** Writes are issued before the checksum is verified. A NAK tells the host to resend the whole frame; the block performs no rollback.

**Timeout.** In `ADDR`, `LEN`, `DATA` or `CSUM`, a counter runs from the end of each byte. If `TIMEOUT_BITS*BAUD_CNT_MAX` cycles pass with no new start edge:
- the FSM goes to `SYNC`;
- `busy_o` falls;
- no response is sent.

The timeout counter does not run in `SYNC` or `RESP`.

**Bytes during RESP.** Bytes received during `RESP` are discarded.

## Timing
**Reset values.**
- `uart_tx_o` = 1.
- `busy_o`, `mem_wr_en_o` = 0.
- `mem_wr_addr_o`, `mem_wr_data_o` = 0.
- The FSM is in `SYNC`; the RX and TX FSMs are idle; all counters are 0.

**Reset mid-operation.** Asserting `rst` in any state aborts the frame at the next edge:
- outputs return to their reset values;
- a TX byte in progress is truncated, with the line high;
- no partial write is issued.

**Latencies.**
- `rx_valid` fires in the cycle after the stop-bit mid-sample.
- `busy_o` rises in the cycle after the 0xA5 `rx_valid`.
- `mem_wr_en_o` is high for exactly 1 cycle, in the cycle after the `rx_valid` of the 4th byte of each word. Address and data are valid in that same cycle and hold until the next write.
- The response start bit drives `uart_tx_o` low in the cycle after the checksum `rx_valid`.
- The TX frame lasts `10*BAUD_CNT_MAX` cycles. `busy_o` falls in the cycle after the stop bit ends.

**Boundaries.**
- `N` = 0xFFFF is legal.
- An address wrap past 0xFFFFFFFC wraps to 0.
- An 0xA5 byte inside `ADDR`, `LEN`, `DATA` or `CSUM` is payload, not a resync.

## Test plan
Benches use `CLK_FREQ`=1_000_000 and `UART_BPS`=100_000, so `BAUD_CNT_MAX`=10.

1. **Single-word download.** Send A5, 00 10 00 00, 01 00, 78 56 34 12, 08.
   - Expect one write: addr 0x00001000, data 0x12345678.
   - Expect TX 0x5A.
   - Expect `busy_o` high from the 0xA5 byte through the end of the response.
2. **Multi-word download with bad checksum.** Address 0x00000002, N=2, words 0xAABBCCDD and 0x11223344, checksum 0x00.
   - Expect writes at 0x00000000 and 0x00000004.
   - Expect TX 0xEE.
3. **Zero length and sync filtering.** Send garbage bytes 0x00 and 0xFF, then A5, address 0x20, length 00 00, checksum 00.
   - Expect no writes.
   - Expect `busy_o` low during the garbage bytes.
   - Expect TX 0x5A.
4. **Timeout.** Send A5, then 2 address bytes, then silence for 25 bit periods.
   - Expect `busy_o` to fall exactly 200 cycles after the end of the 2nd byte.
   - Expect no TX activity.
   - A following valid frame must be accepted normally.
5. **Framing error.** Corrupt the stop bit to 0 on the 3rd data byte of a frame.
   - Expect return to `SYNC` with no write for that word and no response.
6. **Reset mid-word.** Assert `rst` for 1 cycle after 2 data bytes.
   - Expect all outputs at reset values on the next cycle.
   - Expect no `mem_wr_en_o` pulse.
   - A subsequent frame must work.
